// File: rtl/keys_debounce_ev_if.sv
// Key front-end bundle: raw pad levels in, debounced level and one-cycle
// event pulses out.
//   input_keys  : raw pad levels, asynchronous to the consumer clock
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle pulse per accepted press
//   key_release : one-cycle pulse per accepted release
//   key_long    : one-cycle pulse once a press has lasted the long-press time
//   key_repeat  : one-cycle auto-repeat pulse while held after key_long
// master = the debounce block, slave = the pad source / event consumer.
interface keys_debounce_ev_if #(
    parameter int N = 4
);
    logic [N-1:0] input_keys;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;
    logic [N-1:0] key_repeat;

    modport master (
        input  input_keys,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat
    );

    modport slave (
        output input_keys,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat
    );
endinterface

// File: rtl/keys_debounce_ev.sv
// N-channel push-button front end: 2-flop synchroniser, polarity
// normalisation, stability-window debounce, and press/release/long/repeat
// one-cycle event generation. Channels share nothing.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   kif   : keys_debounce_ev_if master modport (pads in, level/events out)
module keys_debounce_ev #(
    parameter int N          = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_MAX    = 1_000_000,
    parameter int LONG_MAX   = 50_000_000,
    parameter int REPEAT_EN  = 1,
    parameter int REPEAT_MAX = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    keys_debounce_ev_if.master kif
);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int LW = $clog2(LONG_MAX + 1);
    localparam int RW = $clog2(REPEAT_MAX + 1);

    // Pad level when released; XOR with it gives pressed = 1.
    localparam logic PAD_INV = (ACTIVE_LOW != 0);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
    localparam logic [LW-1:0] LONG_DONE = LW'(LONG_MAX);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_MAX - 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } hold_st_e;

    logic [N-1:0] level_v;
    logic [N-1:0] press_v;
    logic [N-1:0] release_v;
    logic [N-1:0] long_v;
    logic [N-1:0] repeat_v;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic            sync1_q, sync2_q;
        logic            sample;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic            level_q, level_d;
        logic            press_q, release_q;
        logic            toggle, press_ev, release_ev;
        hold_st_e        st_q;
        logic [LW-1:0]   hold_q;
        logic [RW-1:0]   rep_q;
        logic            long_q, repeat_q;

        assign sample = sync2_q ^ PAD_INV;

        // Counter only ever reaches CNT_MAX-1; the cycle it would hit
        // CNT_MAX is the toggle cycle and it clears instead.
        always_comb begin
            cnt_d  = '0;
            toggle = 1'b0;
            if (sample != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    toggle = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        assign level_d    = level_q ^ toggle;
        assign press_ev   = toggle & ~level_q;
        assign release_ev = toggle &  level_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q   <= PAD_INV;
                sync2_q   <= PAD_INV;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= kif.input_keys[g];
                sync2_q   <= sync1_q;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_ev;
                release_q <= release_ev;
            end
        end

        // Hold FSM reacts to the same-cycle release event, so a release
        // landing on a due long/repeat pulse suppresses that pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q     <= ST_IDLE;
                hold_q   <= '0;
                rep_q    <= '0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
                case (st_q)
                    ST_IDLE: begin
                        if (press_ev) begin
                            st_q   <= ST_HOLD;
                            hold_q <= '0;
                            rep_q  <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (release_ev) begin
                            st_q   <= ST_IDLE;
                            hold_q <= '0;
                            rep_q  <= '0;
                        end else if (hold_q != LONG_DONE) begin
                            if (hold_q == LONG_LAST) begin
                                long_q <= 1'b1;
                            end
                            hold_q <= hold_q + 1'b1;
                        end else if (REPEAT_EN != 0) begin
                            if (rep_q == REP_LAST) begin
                                repeat_q <= 1'b1;
                                rep_q    <= '0;
                            end else begin
                                rep_q <= rep_q + 1'b1;
                            end
                        end
                    end
                    default: st_q <= ST_IDLE;
                endcase
            end
        end

        assign level_v[g]   = level_q;
        assign press_v[g]   = press_q;
        assign release_v[g] = release_q;
        assign long_v[g]    = long_q;
        assign repeat_v[g]  = repeat_q;
    end

    assign kif.key_level   = level_v;
    assign kif.key_press   = press_v;
    assign kif.key_release = release_v;
    assign kif.key_long    = long_v;
    assign kif.key_repeat  = repeat_v;
endmodule

// File: doc/keys_debounce_ev.md
# keys_debounce_ev

Parametrised N-channel push-button front end that synchronises raw pad inputs, removes contact bounce with a programmable stability window, and turns each debounced key into a level plus single-cycle event pulses: press, release, long-press and auto-repeat. It sits between the board key pins and the user-interface control logic. Downstream FSMs consume one-cycle events instead of doing their own edge detection and hold timing.

## Interface
- N, 4: number of independent key channels.
- ACTIVE_LOW, 1: 1 = pad reads 0 when pressed; 0 = pad reads 1 when pressed.
- CNT_MAX, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- LONG_MAX, 50_000_000: cycles from press event to long-press event (1 s at 50 MHz).
- REPEAT_EN, 1: 1 = emit auto-repeat pulses after a long press.
- REPEAT_MAX, 10_000_000: auto-repeat period in cycles (200 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- input_keys  in  N  raw pad levels, asynchronous to clk.
- key_level  out  N  debounced state, 1 = pressed, regardless of ACTIVE_LOW.
- key_press  out  N  one-cycle pulse on each accepted press.
- key_release  out  N  one-cycle pulse on each accepted release.
- key_long  out  N  one-cycle pulse when a press has lasted LONG_MAX cycles.
- key_repeat  out  N  one-cycle pulse every REPEAT_MAX cycles after key_long while held.

## Operation
- Per channel: 2-flop synchroniser, then polarity normalisation to pressed = 1. Each channel is fully independent; no shared counters.
- Debounce counter, width $clog2(CNT_MAX+1):
  - Cleared whenever the synchronised sample equals key_level.
  - Increments whenever the sample differs.
  - When it would reach CNT_MAX, key_level toggles and the counter clears.
  - Any sample equal to key_level before then clears the counter, so a glitch shorter than CNT_MAX cycles is discarded.
- Event pulses:
  - key_press is registered and high exactly in the first cycle key_level reads 1.
  - key_release is high exactly in the first cycle key_level reads 0.
- Hold logic, two states per channel:
  - IDLE to HOLD on the press event; the hold counter starts at 0.
  - In HOLD the counter increments each cycle. At LONG_MAX, key_long pulses and the repeat counter starts.
  - If REPEAT_EN = 1, key_repeat pulses every REPEAT_MAX cycles until release. The repeat counter wraps to 0 on each pulse.
  - Any release returns the channel to IDLE, clears both counters and suppresses all pending events.
- Counters never overflow: the hold counter stops at LONG_MAX; only the repeat counter runs afterwards.
- A release that becomes valid in the same cycle a long or repeat pulse is due: the release wins, and no long or repeat pulse is emitted.

## Timing
- Reset state (asynchronous, takes effect immediately):
  - Synchroniser flops hold the inactive pad level (1 if ACTIVE_LOW, else 0).
  - Every output is 0.
  - All counters are 0 and every channel is in IDLE.
- Press latency: the pad change is first sampled at edge e0. key_level and key_press assert after edge e(CNT_MAX+1), which is CNT_MAX+2 edges in total. Release latency is identical.
- key_long asserts exactly LONG_MAX cycles after the key_press cycle.
- The first key_repeat follows key_long by REPEAT_MAX cycles. Later repeats are spaced by REPEAT_MAX cycles.
- All pulses last exactly 1 cycle. Pulses on different channels may coincide.
- Reset mid-operation: if a key is still held when rst_n deasserts, the block treats it as a new press. key_press fires CNT_MAX+2 edges later.

## Test plan
All scenarios use N=4, ACTIVE_LOW=1, CNT_MAX=8, LONG_MAX=40, REPEAT_MAX=10, unless stated.
- Reset: rst_n=0 with all pads at 1 → all outputs 0. Pulse rst_n mid-clock → outputs 0 immediately, with no clock edge needed.
- Clean press of ch0: pad 0 low for 120 cycles, then high.
  - key_level[0] rises 10 edges after the first sampling edge, with a 1-cycle key_press[0].
  - key_long[0] fires 40 cycles after the press; key_repeat[0] fires at +50, +60, +70 …
  - key_release[0] fires 10 edges after release, and no further repeats follow.
- Bounce and glitch:
  - Ch1 toggles every 3 cycles for 30 cycles, then holds low → exactly one key_press[1], 10 edges after the final edge.
  - A 7-cycle low glitch produces no events; an 8-cycle low produces a press.
- Independence: ch2 and ch3 are pressed 5 cycles apart and ch2 is released early → each channel's events appear at its own computed cycles, and ch3's long and repeat pulses are unaffected.
- Release/long collision: release ch0 so that key_level drops in the cycle key_long is due → key_release only, with no key_long. Rerun with REPEAT_EN=0 and a 100-cycle hold → one key_long and zero key_repeat.
- Reset while held: assert rst_n during a ch0 hold, then deassert with the pad still low → all outputs 0 during reset, and a fresh key_press[0] 10 edges after deassertion.
